// File: rtl/pc_pkg.sv
// pc_pkg -- shared definitions for the fetch-stage program-counter logic.
//
// Contents:
//   pc_action_e : the single action the sequencer takes in a cycle.
//   pc_select() : fixed-priority resolution of the control strobes
//                 (stall > ret > call > jump > branch > increment).
// Decode and trace logic reuse both so that they agree with the sequencer
// on which strobe won in a given cycle.
package pc_pkg;

   typedef enum logic [2:0] {
      PC_INC,
      PC_BR,
      PC_JMP,
      PC_CALL,
      PC_RET,
      PC_HOLD
   } pc_action_e;

   // Lower-priority strobes raised in the same cycle are simply dropped.
   function automatic pc_action_e pc_select(input logic i_stall,
                                            input logic i_ret,
                                            input logic i_call,
                                            input logic i_jump,
                                            input logic i_branch);
      pc_action_e w_act;
      if (i_stall)       w_act = PC_HOLD;
      else if (i_ret)    w_act = PC_RET;
      else if (i_call)   w_act = PC_CALL;
      else if (i_jump)   w_act = PC_JMP;
      else if (i_branch) w_act = PC_BR;
      else               w_act = PC_INC;
      return w_act;
   endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras -- circular hardware return-address stack.
//
// Ports:
//   clk   in  1      clock, rising edge
//   rst   in  1      synchronous active-high reset (clears pointer and count)
//   push  in  1      write din as the new top entry
//   pop   in  1      discard the top entry (ignored when empty)
//   din   in  AW     address to push
//   top   out AW     current top entry (valid while count != 0)
//   count out CW     number of valid entries, saturating at DEPTH
//
// Pushing while full overwrites the oldest entry: with every slot in use,
// the slot after the top pointer is the oldest one, so advancing the
// pointer and writing there drops it naturally. push and pop are never
// asserted together by the sequencer; push wins if they are.
module pc_ras
   import pc_pkg::*;
#(
   parameter int AW    = 8,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] din,
   output logic [AW-1:0] top,
   output logic [CW-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [AW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_top;
   logic [CW-1:0] r_count;

   logic [PW-1:0] w_next_ptr;
   logic [PW-1:0] w_prev_ptr;

   // Explicit wrap so DEPTH need not be a power of two.
   assign w_next_ptr = (r_top == LAST_IDX) ? '0 : r_top + PW'(1);
   assign w_prev_ptr = (r_top == '0) ? LAST_IDX : r_top - PW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_top   <= '0;
         r_count <= '0;
      end else if (push) begin
         r_top <= w_next_ptr;
         if (r_count != FULL_CNT) r_count <= r_count + CW'(1);
      end else if (pop && (r_count != '0)) begin
         r_top   <= w_prev_ptr;
         r_count <= r_count - CW'(1);
      end
   end

   // Entry storage is not reset; contents are meaningless until pushed.
   always_ff @(posedge clk) begin
      if (!rst && push) r_mem[w_next_ptr] <= din;
   end

   assign top   = r_mem[r_top];
   assign count = r_count;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer -- fetch-stage program counter with stall, jump, relative
// branch and call/return through a small return-address stack.
//
// Ports:
//   clk       in  1   clock, rising edge
//   rst       in  1   synchronous active-high reset; beats every other input
//   stall     in  1   hold all state, strobes ignored
//   jump      in  1   pc <= tgt
//   branch    in  1   pc <= pc + off (off signed)
//   call      in  1   push pc+STEP, pc <= tgt
//   ret       in  1   pc <= RAS top (or pc+STEP with unf if RAS empty)
//   tgt       in  AW  absolute target for jump/call
//   off       in  AW  two's-complement branch offset
//   pc        out AW  current instruction address (registered)
//   ras_count out CW  valid RAS entries
//   ras_empty out 1   ras_count == 0
//   ras_full  out 1   ras_count == RAS_DEPTH
//   ovf       out 1   sticky: call while RAS full
//   unf       out 1   sticky: ret while RAS empty
//
// All address arithmetic wraps modulo 2^AW. Priority among strobes:
// ret > call > jump > branch > increment; only one acts per cycle, so the
// RAS never sees a push and a pop together.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int            AW         = 8,
   parameter int            STEP       = 1,
   parameter logic [AW-1:0] RESET_ADDR = '0,
   parameter int            RAS_DEPTH  = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           stall,
   input  logic                           jump,
   input  logic                           branch,
   input  logic                           call,
   input  logic                           ret,
   input  logic [AW-1:0]                  tgt,
   input  logic [AW-1:0]                  off,
   output logic [AW-1:0]                  pc,
   output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
   output logic                           ras_empty,
   output logic                           ras_full,
   output logic                           ovf,
   output logic                           unf
);

   localparam int CW = $clog2(RAS_DEPTH + 1);

   logic [AW-1:0] r_pc;
   logic          r_ovf;
   logic          r_unf;

   pc_action_e    w_action;
   logic [AW-1:0] w_pc_inc;
   logic [AW-1:0] w_pc_br;
   logic [AW-1:0] w_pc_next;
   logic [AW-1:0] w_ras_top;
   logic [CW-1:0] w_ras_count;
   logic          w_ras_empty;
   logic          w_ras_full;
   logic          w_push;
   logic          w_pop;

   assign w_action = pc_select(stall, ret, call, jump, branch);

   // Plain AW-bit adds give the modulo-2^AW wrap; a signed offset adds
   // the same way as an unsigned one in two's complement.
   assign w_pc_inc = r_pc + AW'(STEP);
   assign w_pc_br  = r_pc + off;

   assign w_ras_empty = (w_ras_count == '0);
   assign w_ras_full  = (w_ras_count == CW'(RAS_DEPTH));

   // The pushed return address is the fall-through of the call itself.
   assign w_push = !rst && (w_action == PC_CALL);
   assign w_pop  = !rst && (w_action == PC_RET) && !w_ras_empty;

   pc_ras #(
      .AW    (AW),
      .DEPTH (RAS_DEPTH),
      .CW    (CW)
   ) u_ras (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_pc_inc),
      .top   (w_ras_top),
      .count (w_ras_count)
   );

   always_comb begin
      w_pc_next = r_pc;
      case (w_action)
         PC_RET:  w_pc_next = w_ras_empty ? w_pc_inc : w_ras_top;
         PC_CALL: w_pc_next = tgt;
         PC_JMP:  w_pc_next = tgt;
         PC_BR:   w_pc_next = w_pc_br;
         PC_INC:  w_pc_next = w_pc_inc;
         PC_HOLD: w_pc_next = r_pc;
         default: w_pc_next = r_pc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc  <= RESET_ADDR;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         r_pc <= w_pc_next;
         if ((w_action == PC_CALL) && w_ras_full)  r_ovf <= 1'b1;
         if ((w_action == PC_RET)  && w_ras_empty) r_unf <= 1'b1;
      end
   end

   assign pc        = r_pc;
   assign ras_count = w_ras_count;
   assign ras_empty = w_ras_empty;
   assign ras_full  = w_ras_full;
   assign ovf       = r_ovf;
   assign unf       = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- self-checking bench for pc_sequencer with
// AW=8, STEP=1, RESET_ADDR=8'h10, RAS_DEPTH=4.
// A reference model (pc plus a queue used as the return stack) computes the
// expected pc whenever a cycle is driven and pushes it into exp_q; each test
// pops and compares after the clock edge.
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       stall = 1'b0;
   logic       jump = 1'b0;
   logic       branch = 1'b0;
   logic       call = 1'b0;
   logic       ret = 1'b0;
   logic [7:0] tgt = 8'h00;
   logic [7:0] off = 8'h00;
   logic [7:0] pc;
   logic [2:0] ras_count;
   logic       ras_empty;
   logic       ras_full;
   logic       ovf;
   logic       unf;

   int errors = 0;
   int checks = 0;

   // scoreboard and model state
   logic [7:0] exp_q[$];
   logic [7:0] m_pc = 8'h10;
   logic [7:0] m_stack[$];
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;

   pc_sequencer #(
      .AW         (8),
      .STEP       (1),
      .RESET_ADDR (8'h10),
      .RAS_DEPTH  (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .jump      (jump),
      .branch    (branch),
      .call      (call),
      .ret       (ret),
      .tgt       (tgt),
      .off       (off),
      .pc        (pc),
      .ras_count (ras_count),
      .ras_empty (ras_empty),
      .ras_full  (ras_full),
      .ovf       (ovf),
      .unf       (unf)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- driver ----------------
   // Drive one cycle of strobes, update the model, push the expected pc,
   // then wait until just after the rising edge.
   task automatic drive(input logic r, input logic s, input logic rt,
                        input logic cl, input logic jp, input logic br,
                        input logic [7:0] t, input logic [7:0] o);
      rst = r; stall = s; ret = rt; call = cl; jump = jp; branch = br;
      tgt = t; off = o;
      if (r) begin
         m_pc = 8'h10;
         m_stack.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else if (s) begin
         m_pc = m_pc;
      end else if (rt) begin
         if (m_stack.size() > 0) m_pc = m_stack.pop_back();
         else begin
            m_pc = m_pc + 8'd1;
            m_unf = 1'b1;
         end
      end else if (cl) begin
         if (m_stack.size() == 4) begin
            m_ovf = 1'b1;
            void'(m_stack.pop_front());
         end
         m_stack.push_back(m_pc + 8'd1);
         m_pc = t;
      end else if (jp) begin
         m_pc = t;
      end else if (br) begin
         m_pc = m_pc + o;
      end else begin
         m_pc = m_pc + 8'd1;
      end
      exp_q.push_back(m_pc);
      @(posedge clk);
      #1;
      rst = 1'b0; stall = 1'b0; ret = 1'b0; call = 1'b0; jump = 1'b0; branch = 1'b0;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [7:0] e;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      e = exp_q.pop_front();
      checks++;
      if (pc !== e || pc !== 8'h10) begin
         errors++; $display("FAIL reset_pc: got %h want %h", pc, e);
      end
      checks++;
      if (ras_count !== 3'd0 || ras_empty !== 1'b1 || ras_full !== 1'b0) begin
         errors++; $display("FAIL reset_ras: got count=%0d empty=%b full=%b want 0/1/0",
                             ras_count, ras_empty, ras_full);
      end
      checks++;
      if (ovf !== 1'b0 || unf !== 1'b0) begin
         errors++; $display("FAIL reset_flags: got ovf=%b unf=%b want 0/0", ovf, unf);
      end
      for (int i = 1; i <= 3; i++) begin
         idle();
         e = exp_q.pop_front();
         checks++;
         if (pc !== e || pc !== 8'(8'h10 + i)) begin
            errors++; $display("FAIL idle_pc[%0d]: got %h want %h", i, pc, e);
         end
         checks++;
         if (ras_empty !== 1'b1 || ovf !== 1'b0 || unf !== 1'b0) begin
            errors++; $display("FAIL idle_flags[%0d]: got empty=%b ovf=%b unf=%b want 1/0/0",
                                i, ras_empty, ovf, unf);
         end
      end
   endtask

   task automatic test_branch_jump();
      logic [7:0] e;
      logic [7:0] wrap_tbl [3] = '{8'hFE, 8'hFF, 8'h00};
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h20, 8'h00);
      void'(exp_q.pop_front());
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hF0);
      e = exp_q.pop_front();
      checks++;
      if (pc !== e || pc !== 8'h10) begin
         errors++; $display("FAIL branch_neg: got %h want %h", pc, e);
      end
      for (int i = 0; i < 3; i++) begin
         if (i == 0) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFE, 8'h00);
         else idle();
         e = exp_q.pop_front();
         checks++;
         if (pc !== e || pc !== wrap_tbl[i]) begin
            errors++; $display("FAIL jump_wrap[%0d]: got %h want %h", i, pc, wrap_tbl[i]);
         end
      end
   endtask

   task automatic test_call_ret();
      logic [7:0] e;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h30, 8'h00);
      void'(exp_q.pop_front());
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 8'h00);
      e = exp_q.pop_front();
      checks++;
      if (pc !== e || ras_count !== 3'd1) begin
         errors++; $display("FAIL call_pc: got pc=%h count=%0d want pc=%h count=1", pc, ras_count, e);
      end
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      e = exp_q.pop_front();
      checks++;
      if (pc !== e || pc !== 8'h31 || ras_empty !== 1'b1) begin
         errors++; $display("FAIL ret_b2b: got pc=%h empty=%b want pc=31 empty=1", pc, ras_empty);
      end
   endtask

   task automatic test_nested();
      logic [7:0] e;
      logic [7:0] call_tbl [5] = '{8'h40, 8'h50, 8'h60, 8'h70, 8'h90};
      logic [7:0] ret_tbl  [4] = '{8'h71, 8'h61, 8'h51, 8'h41};
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      void'(exp_q.pop_front());
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, call_tbl[i], 8'h00);
         e = exp_q.pop_front();
         checks++;
         if (pc !== e || ras_count !== 3'(m_stack.size())) begin
            errors++; $display("FAIL nest_call[%0d]: got pc=%h count=%0d want pc=%h count=%0d",
                                i, pc, ras_count, e, m_stack.size());
         end
      end
      checks++;
      if (ovf !== 1'b1 || ras_count !== 3'd4 || ras_full !== 1'b1) begin
         errors++; $display("FAIL nest_ovf: got ovf=%b count=%0d full=%b want 1/4/1", ovf, ras_count, ras_full);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
         e = exp_q.pop_front();
         checks++;
         if (pc !== e || pc !== ret_tbl[i]) begin
            errors++; $display("FAIL nest_ret[%0d]: got %h want %h", i, pc, ret_tbl[i]);
         end
      end
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      e = exp_q.pop_front();
      checks++;
      if (pc !== 8'h42 || unf !== 1'b1 || ras_count !== 3'd0) begin
         errors++; $display("FAIL nest_unf: got pc=%h unf=%b count=%0d want 42/1/0", pc, unf, ras_count);
      end
   endtask

   task automatic test_priority();
      logic [7:0] e;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      void'(exp_q.pop_front());
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h77, 8'h05);
      e = exp_q.pop_front();
      checks++;
      if (pc !== e || pc !== 8'h11 || unf !== 1'b1 || ras_count !== 3'd0) begin
         errors++; $display("FAIL prio_ret: got pc=%h unf=%b count=%0d want 11/1/0", pc, unf, ras_count);
      end
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h77, 8'h05);
      e = exp_q.pop_front();
      checks++;
      if (pc !== e || pc !== 8'h11 || ras_count !== 3'd0 || ovf !== 1'b0) begin
         errors++; $display("FAIL prio_stall: got pc=%h count=%0d ovf=%b want 11/0/0", pc, ras_count, ovf);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] e;
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h20 * (i + 1)), 8'h00);
         void'(exp_q.pop_front());
      end
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      e = exp_q.pop_front();
      checks++;
      if (pc !== e || ras_count !== 3'd3 || ovf !== 1'b1) begin
         errors++; $display("FAIL mid_setup: got pc=%h count=%0d ovf=%b want %h/3/1", pc, ras_count, ovf, e);
      end
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hAA, 8'h00);
      e = exp_q.pop_front();
      checks++;
      if (pc !== 8'h10 || ras_count !== 3'd0 || ovf !== 1'b0 || unf !== 1'b0) begin
         errors++; $display("FAIL mid_reset: got pc=%h count=%0d ovf=%b unf=%b want 10/0/0/0",
                             pc, ras_count, ovf, unf);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] e;
      for (int i = 0; i < 80; i++) begin
         drive(1'b0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 4) == 0), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)));
         e = exp_q.pop_front();
         checks++;
         if (pc !== e || ras_count !== 3'(m_stack.size()) || ovf !== m_ovf || unf !== m_unf) begin
            errors++; $display("FAIL rand[%0d]: got pc=%h cnt=%0d ovf=%b unf=%b want pc=%h cnt=%0d ovf=%b unf=%b",
                                i, pc, ras_count, ovf, unf, e, m_stack.size(), m_ovf, m_unf);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_branch_jump();
      test_call_ret();
      test_nested();
      test_priority();
      test_reset_mid();
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
